// File: rtl/muldiv_sequencer_pkg.sv
// Shared op/state encodings and constants for the iterative HI/LO multiply/divide unit.
// Also imported by the hazard/forwarding unit to decode op.
package muldiv_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } state_e;

  // Quotient reported for a zero divisor; sliced to WIDTH by the user.
  localparam logic [63:0] DIV0_QUOT = '1;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate: abs-value at launch, sign restore in FIX.
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; one shared adder, WIDTH steps per op.
// Optional MULDIV_EARLY_OUT_EN: multiplies leave CALC once no multiplier bits remain.
import muldiv_sequencer_pkg::*;

module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam int SW = 2 * WIDTH + 1;

  state_e               state_q, state_d;
  logic                 div_q, neg_q, neg_r, dz_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   acc_q;    // mult: product; div: {remainder, quotient/dividend}
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     opb_q;    // multiplier (shifts right) or divisor
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [SW-1:0]        add_a, add_b, sum;
  logic                 add_cin, div_ok, calc_last, launch, sgn;
  logic [2*WIDTH-1:0]   prod_f;
  logic [WIDTH-1:0]     quo_f, rem_f, res_hi, res_lo;

  assign sgn = op_is_signed(op);

  muldiv_signfix #(.W(WIDTH)) u_abs_a (.val(rs_val), .neg(sgn & rs_val[WIDTH-1]), .res(abs_a));
  muldiv_signfix #(.W(WIDTH)) u_abs_b (.val(rt_val), .neg(sgn & rt_val[WIDTH-1]), .res(abs_b));

  // Shared datapath: accumulate for multiply, trial subtract for divide.
  always_comb begin
    add_a   = {1'b0, acc_q};
    add_b   = '0;
    add_cin = 1'b0;
    if (div_q) begin
      add_a   = {{WIDTH{1'b0}}, acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      add_b   = ~{{(WIDTH+1){1'b0}}, opb_q};
      add_cin = 1'b1;
    end else if (opb_q[0]) begin
      add_b = {1'b0, mcand_q};
    end
  end

  assign sum    = add_a + add_b + SW'(add_cin);
  assign div_ok = ~sum[SW-1];

`ifdef MULDIV_EARLY_OUT_EN
  assign calc_last = (cnt_q == '0) || (!div_q && (opb_q[WIDTH-1:1] == '0));
`else
  assign calc_last = (cnt_q == '0);
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CALC;
      S_CALC:  if (calc_last) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  assign launch = (state_q == S_IDLE) && (state_d == S_CALC);

  muldiv_signfix #(.W(2*WIDTH)) u_fix_p (.val(acc_q), .neg(neg_q), .res(prod_f));
  muldiv_signfix #(.W(WIDTH)) u_fix_q (.val(acc_q[WIDTH-1:0]), .neg(neg_q), .res(quo_f));
  muldiv_signfix #(.W(WIDTH)) u_fix_r (.val(acc_q[2*WIDTH-1:WIDTH]), .neg(neg_r), .res(rem_f));

  assign res_hi = div_q ? rem_f : prod_f[2*WIDTH-1:WIDTH];
  assign res_lo = div_q ? (dz_q ? DIV0_QUOT[WIDTH-1:0] : quo_f) : prod_f[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      opb_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != S_IDLE);
      done    <= (state_q == S_FIX) && !flush;
      if (launch) begin
        div_q   <= op_is_div(op);
        neg_q   <= sgn & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
        neg_r   <= sgn & rs_val[WIDTH-1];
        dz_q    <= (rt_val == '0);
        acc_q   <= op_is_div(op) ? {{WIDTH{1'b0}}, abs_a} : '0;
        mcand_q <= {{WIDTH{1'b0}}, abs_a};
        opb_q   <= abs_b;
        cnt_q   <= CW'(WIDTH - 1);
      end else if (state_q == S_CALC) begin
        cnt_q <= cnt_q - 1'b1;
        if (div_q) begin
          acc_q <= div_ok ? {sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                          : {acc_q[2*WIDTH-2:0], 1'b0};
        end else begin
          acc_q   <= sum[2*WIDTH-1:0];
          mcand_q <= mcand_q << 1;
          opb_q   <= opb_q >> 1;
        end
      end else if (state_q == S_FIX) begin
        if (!flush) begin
          hi <= res_hi;
          lo <= res_lo;
        end
      end else if (!start) begin
        // Moves to HI/LO only land while idle and not displaced by a launch.
        if (mthi) hi <= wr_data;
        if (mtlo) lo <= wr_data;
      end
    end
  end

endmodule
